// File: rtl/decode_regfile_stage.sv
// Y86-64 decode stage with integrated register file and a single registered output stage.
// Optional macro DECODE_WB_BYPASS_EN forwards same-edge write-back data into captured operands.
module decode_regfile_stage #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int RSP_ID = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              wb_en,
    input  logic [3:0]        wb_dstE,
    input  logic [DATA_W-1:0] wb_valE,
    input  logic [3:0]        wb_dstM,
    input  logic [DATA_W-1:0] wb_valM,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        icode_o,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'(RSP_ID);

    logic [DATA_W-1:0] regs   [NREG];
    logic [DATA_W-1:0] rd_tab [16];
    logic [3:0]        src_a_next, src_b_next, dst_e_next, dst_m_next;
    logic [DATA_W-1:0] val_a_next, val_b_next;
    logic              accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // One flop bank per implemented register; M write takes priority over E on the same ID.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs[gi] <= '0;
            end else if (wb_en && wb_dstM == 4'(gi)) begin
                regs[gi] <= wb_valM;
            end else if (wb_en && wb_dstE == 4'(gi)) begin
                regs[gi] <= wb_valE;
            end
        end
    end

    // Full 16-entry read table: unimplemented IDs and RNONE read as zero.
    for (genvar gi = 0; gi < 16; gi++) begin : g_rd
        if (gi < NREG) begin : g_impl
            assign rd_tab[gi] = regs[gi];
        end else begin : g_zero
            assign rd_tab[gi] = '0;
        end
    end

    always_comb begin
        src_a_next = RNONE;
        src_b_next = RNONE;
        dst_e_next = RNONE;
        dst_m_next = RNONE;
        case (icode)
            4'h2: begin src_a_next = rA;  dst_e_next = rB; end
            4'h3: begin dst_e_next = rB; end
            4'h4: begin src_a_next = rA;  src_b_next = rB; end
            4'h5: begin src_b_next = rB;  dst_m_next = rA; end
            4'h6: begin src_a_next = rA;  src_b_next = rB;  dst_e_next = rB; end
            4'h8: begin src_b_next = RSP; dst_e_next = RSP; end
            4'h9: begin src_a_next = RSP; src_b_next = RSP; dst_e_next = RSP; end
            4'hA: begin src_a_next = rA;  src_b_next = RSP; dst_e_next = RSP; end
            4'hB: begin src_a_next = RSP; src_b_next = RSP; dst_e_next = RSP; dst_m_next = rA; end
            default: ;
        endcase
    end

    always_comb begin
        val_a_next = rd_tab[src_a_next];
        val_b_next = rd_tab[src_b_next];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && src_a_next != RNONE && 32'(src_a_next) < NREG) begin
            if (src_a_next == wb_dstM)      val_a_next = wb_valM;
            else if (src_a_next == wb_dstE) val_a_next = wb_valE;
        end
        if (wb_en && src_b_next != RNONE && 32'(src_b_next) < NREG) begin
            if (src_b_next == wb_dstM)      val_b_next = wb_valM;
            else if (src_b_next == wb_dstE) val_b_next = wb_valE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            icode_o   <= 4'h0;
            srcA      <= RNONE;
            srcB      <= RNONE;
            dstE      <= RNONE;
            dstM      <= RNONE;
            valA      <= '0;
            valB      <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            icode_o   <= icode;
            srcA      <= src_a_next;
            srcB      <= src_b_next;
            dstE      <= dst_e_next;
            dstM      <= dst_m_next;
            valA      <= val_a_next;
            valB      <= val_b_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_regfile_stage.sv
// Directed self-checking bench for decode_regfile_stage (instance built with NREG=8).
module tb_decode_regfile_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  icode, rA, rB;
    logic        wb_en;
    logic [3:0]  wb_dstE, wb_dstM;
    logic [63:0] wb_valE, wb_valM;
    logic        out_valid, out_ready;
    logic [3:0]  icode_o, srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    decode_regfile_stage #(.DATA_W(64), .NREG(8), .RSP_ID(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .rA(rA), .rB(rB), .wb_en(wb_en),
        .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
        .out_valid(out_valid), .out_ready(out_ready), .icode_o(icode_o),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM), .valA(valA), .valB(valB)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
        wb_en = 1'b1; wb_dstE = de; wb_valE = ve; wb_dstM = dm; wb_valM = vm;
        step();
        wb_en = 1'b0; wb_dstE = 4'hF; wb_dstM = 4'hF;
    endtask

    task automatic set_in(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
        in_valid = 1'b1; icode = ic; rA = a; rB = b;
    endtask

    task automatic issue(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
        set_in(ic, a, b);
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_ids(input string tag, input logic [3:0] sa, input logic [3:0] sb,
                           input logic [3:0] de, input logic [3:0] dm);
        chk({tag, ".srcA"}, 64'(srcA), 64'(sa));
        chk({tag, ".srcB"}, 64'(srcB), 64'(sb));
        chk({tag, ".dstE"}, 64'(dstE), 64'(de));
        chk({tag, ".dstM"}, 64'(dstM), 64'(dm));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; icode = 4'h0; rA = 4'hF; rB = 4'hF;
        wb_en = 1'b0; wb_dstE = 4'hF; wb_dstM = 4'hF; wb_valE = '0; wb_valM = '0;
        out_ready = 1'b1;
        step(); step();
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk_ids("rst", 4'hF, 4'hF, 4'hF, 4'hF);
        chk("rst.valA", valA, 64'd0);
        rst_n = 1'b1;
        step();

        // OPq after writing two registers on one edge
        wr(4'd2, 64'h11, 4'd3, 64'h22);
        issue(4'h6, 4'd2, 4'd3);
        chk("opq.out_valid", 64'(out_valid), 64'd1);
        chk("opq.icode", 64'(icode_o), 64'h6);
        chk_ids("opq", 4'd2, 4'd3, 4'd3, 4'hF);
        chk("opq.valA", valA, 64'h11);
        chk("opq.valB", valB, 64'h22);

        // popq reads %rsp twice
        wr(4'd4, 64'h100, 4'hF, 64'd0);
        issue(4'hB, 4'd7, 4'hF);
        chk_ids("popq", 4'd4, 4'd4, 4'd4, 4'd7);
        chk("popq.valA", valA, 64'h100);
        chk("popq.valB", valB, 64'h100);

        // E and M to the same register: M wins
        wr(4'd5, 64'd1, 4'd5, 64'd2);
        issue(4'h2, 4'd5, 4'hF);
        chk_ids("cmov5", 4'd5, 4'hF, 4'hF, 4'hF);
        chk("conflict.valA", valA, 64'd2);
        chk("cmov5.valB", valB, 64'd0);
        step();
        chk("drain.out_valid", 64'(out_valid), 64'd0);

        // Stall: held bundle ignores a later write to its source register
        out_ready = 1'b0;
        issue(4'h6, 4'd2, 4'd3);
        set_in(4'h3, 4'hF, 4'd1);
        wb_en = 1'b1; wb_dstE = 4'd2; wb_valE = 64'h55;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d.in_ready", i), 64'(in_ready), 64'd0);
            chk($sformatf("stall%0d.icode", i), 64'(icode_o), 64'h6);
            chk($sformatf("stall%0d.valA", i), valA, 64'h11);
            step();
            wb_en = 1'b0; wb_dstE = 4'hF;
        end
        out_ready = 1'b1;
        #1;
        chk("unstall.in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("irmov.icode", 64'(icode_o), 64'h3);
        chk_ids("irmov", 4'hF, 4'hF, 4'd1, 4'hF);
        chk("irmov.valA", valA, 64'd0);
        step();
        chk("irmov.drain", 64'(out_valid), 64'd0);
        issue(4'h2, 4'd2, 4'hF);
        chk("stallwr.valA", valA, 64'h55);

        // Same-edge capture of a write to the source register
        wr(4'd6, 64'h5, 4'hF, 64'd0);
        set_in(4'h5, 4'd1, 4'd6);
        wb_en = 1'b1; wb_dstE = 4'd6; wb_valE = 64'hABC;
        step();
        in_valid = 1'b0; wb_en = 1'b0; wb_dstE = 4'hF;
        chk_ids("mrmov", 4'hF, 4'd6, 4'hF, 4'd1);
`ifdef DECODE_WB_BYPASS_EN
        chk("bypass.valB", valB, 64'hABC);
`else
        chk("bypass.valB", valB, 64'h5);
`endif
        issue(4'h2, 4'd6, 4'hF);
        chk("after.valA", valA, 64'hABC);

        // Out-of-range IDs and halt
        wr(4'd9, 64'hDEAD, 4'hF, 64'd0);
        issue(4'h2, 4'd9, 4'hF);
        chk("id9.srcA", 64'(srcA), 64'd9);
        chk("id9.valA", valA, 64'd0);
        issue(4'h2, 4'd1, 4'hF);
        chk("alias1.valA", valA, 64'd0);
        issue(4'h0, 4'd2, 4'd3);
        chk_ids("halt", 4'hF, 4'hF, 4'hF, 4'hF);
        chk("halt.valA", valA, 64'd0);
        chk("halt.valB", valB, 64'd0);
        step();

        // Reset during a stall discards the bundle and clears the file
        out_ready = 1'b0;
        issue(4'h6, 4'd2, 4'd3);
        chk("prerst.out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        chk_ids("midrst", 4'hF, 4'hF, 4'hF, 4'hF);
        chk("midrst.valA", valA, 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        issue(4'h6, 4'd2, 4'd3);
        chk("postrst.valA", valA, 64'd0);
        chk("postrst.valB", valB, 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/decode_regfile_stage.md
# decode_regfile_stage

Parametrised decode stage for the Y86-64 core with an integrated register file.
- Decode: on an accepted instruction, generates source and destination register IDs from icode/rA/rB, reads valA/valB, and registers all results in one output stage with a valid/ready handshake.
- Write-back: an independent two-port interface (E and M) updates the register file every cycle.
- Placement: between fetch and execute. Replaces the unclocked decode with a stall-capable, reset-defined block.

## Interface
Parameters:
- DATA_W, 64: register and value width.
- NREG, 15: number of implemented registers, 1..15. ID 4'hF is RNONE.
- RSP_ID, 4: register ID of %rsp. Must be < NREG.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  stage can accept this cycle.
- icode  in  4  instruction code.
- rA  in  4  rA field.
- rB  in  4  rB field.
- wb_en  in  1  write-back strobe.
- wb_dstE  in  4  E write ID.
- wb_valE  in  DATA_W  E write data.
- wb_dstM  in  4  M write ID.
- wb_valM  in  DATA_W  M write data.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- icode_o  out  4  registered icode.
- srcA  out  4  registered source ID.
- srcB  out  4  registered source ID.
- dstE  out  4  registered destination ID.
- dstM  out  4  registered destination ID.
- valA  out  DATA_W  registered operand.
- valB  out  DATA_W  registered operand.

## Operation
ID generation. N = RNONE. Per icode, the values are srcA / srcB / dstE / dstM:
- 2 cmovxx: rA / N / rB / N
- 3 irmovq: N / N / rB / N
- 4 rmmovq: rA / rB / N / N
- 5 mrmovq: N / rB / N / rA
- 6 OPq: rA / rB / rB / N
- 8 call: N / RSP / RSP / N
- 9 ret: RSP / RSP / RSP / N
- A pushq: rA / RSP / RSP / N
- B popq: RSP / RSP / RSP / rA
- All other icodes: all N.

Reads:
- valA = regs[srcA] and valB = regs[srcB].
- An ID of RNONE, or any ID ≥ NREG, reads as 0.

Writes:
- When wb_en=1, wb_valE is written to regs[wb_dstE] and wb_valM to regs[wb_dstM].
- A write to an ID of RNONE or ≥ NREG is ignored.
- If wb_dstE equals wb_dstM, the M write wins.
- Writes are independent of the handshake and are never blocked.

Handshake:
- in_ready = !out_valid || out_ready. This is combinational and is the only combinational output.
- Accept occurs when in_valid && in_ready. On accept, all output registers load from the current inputs and register file, and out_valid is set to 1.
- When out_valid && out_ready && !in_valid, out_valid clears to 0.
- While out_valid && !out_ready, every output holds stable. valA/valB are not refreshed by later writes; hazard handling belongs to the control unit.

Reset:
- rst_n=0 clears all registers to 0 and forces out_valid=0, icode_o=0, valA=valB=0, and srcA=srcB=dstE=dstM=4'hF.
- in_ready therefore reads 1 during reset.
- Reset asserted mid-stall discards the held bundle.

## Timing
- Latency: an instruction accepted at edge n appears at the outputs after edge n, one cycle later.
- Throughput: one instruction per cycle when out_ready=1.
- Write visibility: a write at edge n is visible to reads captured at edge n+1 or later.
- Same-edge capture: reads captured at edge n see the pre-write value, unless bypass is enabled (see Configuration).
- Back-to-back: accept and output handoff occur on the same edge with no bubble.

## Configuration
- DECODE_WB_BYPASS_EN defined: on an accept edge that coincides with wb_en=1, srcA/srcB matching wb_dstM take wb_valM. Otherwise, a match with wb_dstE takes wb_valE. M has priority over E, and RNONE never matches.
- Not defined: captured values are the register contents before the edge.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1. Outputs go to out_valid=0, srcA..dstM=4'hF, valA=valB=0, and in_ready=1. After release, reading any register returns 0.
- Writes and OPq: write regs[2]=0x11 and regs[3]=0x22, then issue OPq with rA=2, rB=3. One cycle later: valA=0x11, valB=0x22, srcA=2, srcB=3, dstE=3, dstM=F.
- popq with a write conflict: regs[4]=0x100, then issue popq with rA=7, which gives srcA=srcB=4, dstE=4, dstM=7 and valA=valB=0x100. Separately, drive wb_dstE=wb_dstM=5 with valE=1, valM=2; regs[5] reads 2.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1. Required: in_ready=0, outputs stable, and regs[rA] written meanwhile leaves valA unchanged. With out_ready=1, the next instruction is accepted on that edge.
- Bypass: accept mrmovq rB=6 on the same edge as a write of wb_dstE=6, valE=0xABC. Required: valB=0xABC with DECODE_WB_BYPASS_EN, and the old value without it.
- Boundaries: with NREG=8, rA=9 reads 0, and a write to ID 9 is ignored. icode=0 (halt) gives all IDs F and valA=valB=0.
